// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 4-digit common-anode 7-segment scan driver
module display_scan_controller #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lz_en,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [3:0]    dig_q;

    logic          capture;
    logic [15:0]   shadow_eff;
    logic [3:0]    cur_val;
    logic [3:0]    suppress;
    logic [3:0]    dig_n;
    logic [6:0]    seg_n;
    logic          tick_n;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h3F;
        endcase
        return p;
    endfunction

    // Slot counter and digit index; disable parks both at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Frame shadow: one coherent snapshot of all four digits per frame so mid-frame changes never tear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (capture) begin
            shadow <= {bcd3, bcd2, bcd1, bcd0};
        end
    end

    // Capture decision and the digit values seen by this cycle's output (fresh inputs on the capture cycle).
    always_comb begin
        capture     = enable && (cnt == '0) && (idx == 2'd0);
        shadow_eff  = capture ? {bcd3, bcd2, bcd1, bcd0} : shadow;
        cur_val     = shadow_eff[{idx, 2'b00} +: 4];
        suppress    = 4'b0000;
        suppress[3] = lz_en && (shadow_eff[15:12] == 4'd0);
        suppress[2] = suppress[3] && (shadow_eff[11:8] == 4'd0);
        suppress[1] = suppress[2] && (shadow_eff[7:4] == 4'd0);
    end

    // Next output values: dark when disabled, blanking window at slot start, suppressed digits stay off.
    always_comb begin
        dig_n  = 4'hF;
        seg_n  = 7'h7F;
        tick_n = 1'b0;
        if (enable) begin
            tick_n = capture;
            seg_n  = suppress[idx] ? 7'h7F : seg_decode(cur_val);
            if ((cnt >= BLANK_END) && !suppress[idx]) begin
                dig_n[idx] = 1'b0;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_q      <= 4'hF;
            seg        <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            dig_q      <= dig_n;
            seg        <= seg_n;
            frame_tick <= tick_n;
        end
    end

    assign d0 = dig_q[0];
    assign d1 = dig_q[1];
    assign d2 = dig_q[2];
    assign d3 = dig_q[3];

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller
module tb_display_scan_controller;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       lz_en = 1'b0;
    logic [3:0] bcd0 = 4'd0;
    logic [3:0] bcd1 = 4'd0;
    logic [3:0] bcd2 = 4'd0;
    logic [3:0] bcd3 = 4'd0;
    logic       d0, d1, d2, d3;
    logic [6:0] seg;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    int m_t = 0;
    logic [3:0] m_sh [4];
    int low_cnt [4];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .seg(seg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pins();
        return {d3, d2, d1, d0, seg, frame_tick};
    endfunction

    // Predict the outputs after the coming edge, push, clock, then pop and compare.
    task automatic step();
        logic [11:0] e;
        int pos, slot, msd;
        logic sup;
        if (!enable) begin
            e = DARK;
            m_t = 0;
        end else begin
            if (m_t == 0) begin
                m_sh[0] = bcd0; m_sh[1] = bcd1; m_sh[2] = bcd2; m_sh[3] = bcd3;
            end
            pos  = m_t % SD;
            slot = m_t / SD;
            msd  = 0;
            for (int k = 0; k < 4; k++) if (m_sh[k] != 4'd0) msd = k;
            sup = lz_en && (slot > msd);
            e[0]    = (m_t == 0);
            e[7:1]  = sup ? 7'h7F : seg_tab[m_sh[slot]];
            e[11:8] = 4'hF;
            if (pos >= BC && !sup) e[8 + slot] = 1'b0;
            m_t = (m_t + 1) % FRAME;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else check($sformatf("scan_t%0d", (m_t + FRAME - 1) % FRAME), pins(), exp_q.pop_front());
        if (!d0) low_cnt[0]++;
        if (!d1) low_cnt[1]++;
        if (!d2) low_cnt[2]++;
        if (!d3) low_cnt[3]++;
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < FRAME && m_t != t; i++) step();
        check("align", m_t, t);
    endtask

    task automatic clear_lows();
        for (int k = 0; k < 4; k++) low_cnt[k] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
        clear_lows();

        repeat (2) @(posedge clk);
        #1;
        check("reset_pins", pins(), DARK);
        #2 reset = 1'b0;

        // Basic scan 1,2,3,4
        enable = 1'b1;
        bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
        repeat (2 * FRAME) step();

        // Mid-frame input change must wait for next frame
        run_to(5);
        bcd0 = 4'd8;
        repeat (2 * FRAME) step();

        // Leading-zero suppression 0,0,0,5
        lz_en = 1'b1;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd5;
        run_to(0);
        clear_lows();
        repeat (2 * FRAME) step();
        check("lz5_d3_low", low_cnt[3], 0);
        check("lz5_d2_low", low_cnt[2], 0);
        check("lz5_d1_low", low_cnt[1], 0);
        check("lz5_d0_low", low_cnt[0], 2 * (SD - BC));

        // All zero: only digit 0 lit
        bcd0 = 4'd0;
        run_to(0);
        clear_lows();
        repeat (2 * FRAME) step();
        check("lz0_d321_low", low_cnt[1] + low_cnt[2] + low_cnt[3], 0);
        check("lz0_d0_low", low_cnt[0], 2 * (SD - BC));

        // Non-decimal digit shows dash
        lz_en = 1'b0;
        bcd3 = 4'd1; bcd2 = 4'd12; bcd1 = 4'd3; bcd0 = 4'd4;
        run_to(0);
        repeat (2 * FRAME) step();

        // Disable mid digit-2 slot, then re-enable
        run_to(2 * SD + 4);
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (FRAME + 8) step();

        // Asynchronous reset during an active slot
        bcd2 = 4'd2;
        run_to(SD + 4);
        #2 reset = 1'b1;
        #1 check("async_reset_now", pins(), DARK);
        @(posedge clk);
        #1 check("async_reset_held", pins(), DARK);
        #2 reset = 1'b0;
        m_t = 0;
        for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
        check("sb_drained", exp_q.size(), 0);
        repeat (2 * FRAME) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
